// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/click/release/long/repeat events plus held levels.
// Every output is registered, so an event decided at an edge is visible for exactly one cycle after it.
module button_event_gen #(
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held,
  output logic long_active
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES) + 1;

  // Long fires LONG_CYCLES edges after the press edge; repeats every REPEAT_CYCLES edges in HOLD.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             long_active_q, long_active_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (!en) begin
      // Disabling aborts silently: no release is reported for the interrupted press.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_level && !btn_q) begin
            press_d = 1'b1;
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
        PRESS: begin
          if (!btn_level) begin
            release_d = 1'b1;
            short_d   = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else if (cnt_q == LONG_TC) begin
            long_d  = 1'b1;
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!btn_level) begin
            release_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else if (REPEAT_EN && (cnt_q == REPEAT_TC)) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else if (REPEAT_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    held_d        = (state_d != IDLE);
    long_active_d = (state_d == HOLD);
  end

  // btn_q resets high so a button held through reset must be released before it can press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q         <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      held_q        <= 1'b0;
      long_active_q <= 1'b0;
    end else begin
      btn_q         <= btn_level;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
      release_q     <= release_d;
      short_q       <= short_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      held_q        <= held_d;
      long_active_q <= long_active_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign long_active   = long_active_q;

endmodule
